// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO arbiter and its slave interface.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } pio_arb_state_e;

    localparam int PIO_ADDR_W = 16;
    localparam int PIO_DATA_W = 32;

    localparam logic [PIO_DATA_W-1:0] PIO_TIMEOUT_DATA = 32'hDEAD_C0DE;

endpackage

// File: rtl/pio_if.sv
// Single-slave PIO bus: one command channel plus a read-return channel.
interface pio_if;
    import pio_arb_pkg::*;

    logic                  cmd_vld;
    logic [PIO_ADDR_W-1:0] addr;
    logic [PIO_DATA_W-1:0] data_w;
    logic                  rw;
    logic [PIO_DATA_W-1:0] data_r;
    logic                  rd_vld;

    modport master (output cmd_vld, addr, data_w, rw, input data_r, rd_vld);
    modport slave  (input cmd_vld, addr, data_w, rw, output data_r, rd_vld);

endinterface

// File: rtl/pio_rr_arb.sv
// Combinational round-robin picker: first requester above last_gnt, wrapping.
module pio_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_gnt) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pio_arb.sv
// Round-robin sharing of one PIO slave, one transaction in flight.
// Define PIO_ARB_TIMEOUT_EN to abandon reads that get no rd_vld within TIMEOUT cycles.
module pio_arb
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               up_cmd_vld,
    input  logic [NUM_REQ*PIO_ADDR_W-1:0]    up_addr,
    input  logic [NUM_REQ*PIO_DATA_W-1:0]    up_data_w,
    input  logic [NUM_REQ-1:0]               up_rw,
    output logic [NUM_REQ-1:0]               up_cmd_ack,
    output logic [NUM_REQ-1:0]               up_rd_vld,
    output logic [PIO_DATA_W-1:0]            up_data_r,
    output logic                             up_rd_err,
    pio_if.master                            pio
);

    localparam int IDX_W = $clog2(NUM_REQ);

    pio_arb_state_e        state;
    logic [IDX_W-1:0]      last_gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic [NUM_REQ-1:0]    gnt_oh_q;

    logic                  cmd_vld_q;
    logic [PIO_ADDR_W-1:0] addr_q;
    logic [PIO_DATA_W-1:0] data_w_q;
    logic                  rw_q;
    logic [NUM_REQ-1:0]    cmd_ack_q;
    logic [NUM_REQ-1:0]    rd_vld_q;
    logic [PIO_DATA_W-1:0] data_r_q;

    pio_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req      (up_cmd_vld),
        .last_gnt (last_gnt),
        .gnt      (gnt_oh),
        .gnt_idx  (gnt_idx)
    );

`ifdef PIO_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] to_cnt;
    logic             rd_err_q;
    assign up_rd_err = rd_err_q;
`else
    assign up_rd_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= IDX_W'(NUM_REQ - 1);
            gnt_oh_q  <= '0;
            cmd_vld_q <= 1'b0;
            addr_q    <= '0;
            data_w_q  <= '0;
            rw_q      <= 1'b0;
            cmd_ack_q <= '0;
            rd_vld_q  <= '0;
            data_r_q  <= '0;
`ifdef PIO_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            rd_err_q  <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle pulses unless re-asserted below.
            cmd_vld_q <= 1'b0;
            cmd_ack_q <= '0;
            rd_vld_q  <= '0;
`ifdef PIO_ARB_TIMEOUT_EN
            rd_err_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|up_cmd_vld) begin
                        last_gnt  <= gnt_idx;
                        gnt_oh_q  <= gnt_oh;
                        addr_q    <= up_addr[int'(gnt_idx)*PIO_ADDR_W +: PIO_ADDR_W];
                        data_w_q  <= up_data_w[int'(gnt_idx)*PIO_DATA_W +: PIO_DATA_W];
                        rw_q      <= up_rw[gnt_idx];
                        cmd_vld_q <= 1'b1;
                        cmd_ack_q <= gnt_oh;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rw_q) begin
                        state <= IDLE;
                    end else begin
                        state <= WAIT_RD;
`ifdef PIO_ARB_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                end
                WAIT_RD: begin
                    if (pio.rd_vld) begin
                        rd_vld_q <= gnt_oh_q;
                        data_r_q <= pio.data_r;
                        state    <= IDLE;
                    end
`ifdef PIO_ARB_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rd_vld_q <= gnt_oh_q;
                        data_r_q <= PIO_TIMEOUT_DATA;
                        rd_err_q <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pio.cmd_vld = cmd_vld_q;
    assign pio.addr    = addr_q;
    assign pio.data_w  = data_w_q;
    assign pio.rw      = rw_q;
    assign up_cmd_ack  = cmd_ack_q;
    assign up_rd_vld   = rd_vld_q;
    assign up_data_r   = data_r_q;

endmodule

// File: tb/tb_pio_arb.sv
// Scoreboard bench for pio_arb: stimulus queues expected commands/returns, a negedge monitor checks them.
module tb_pio_arb;
    import pio_arb_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      up_cmd_vld;
    logic [N*16-1:0]   up_addr;
    logic [N*32-1:0]   up_data_w;
    logic [N-1:0]      up_rw;
    logic [N-1:0]      up_cmd_ack;
    logic [N-1:0]      up_rd_vld;
    logic [31:0]       up_data_r;
    logic              up_rd_err;

    pio_if pio_bus ();

    pio_arb #(.NUM_REQ(N), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_cmd_vld (up_cmd_vld),
        .up_addr    (up_addr),
        .up_data_w  (up_data_w),
        .up_rw      (up_rw),
        .up_cmd_ack (up_cmd_ack),
        .up_rd_vld  (up_rd_vld),
        .up_data_r  (up_data_r),
        .up_rd_err  (up_rd_err),
        .pio        (pio_bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          req;
        logic [15:0] addr;
        logic [31:0] data;
        logic        rw;
    } cmd_t;

    typedef struct {
        int          cyc;
        int          req;
        logic [31:0] data;
        logic        err;
    } rd_t;

    cmd_t cmd_q[$];
    rd_t  rd_q[$];
    int   cyc = 0;
    int   pend[N];
    int   checks = 0;
    int   failures = 0;
    logic done = 1'b0;
    logic fin = 1'b0;
    cmd_t ce;
    rd_t  re;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (up_cmd_ack[i] && pend[i] > 0) begin
                pend[i]--;
                if (pend[i] == 0) up_cmd_vld[i] = 1'b0;
            end
        end
    endtask

    task automatic req(input int i, input logic [15:0] a, input logic [31:0] d,
                       input logic rw, input int n);
        up_addr[i*16 +: 16]   = a;
        up_data_w[i*32 +: 32] = d;
        up_rw[i]              = rw;
        pend[i]               = n;
        up_cmd_vld[i]         = 1'b1;
    endtask

    task automatic exp_cmd(input int c, input int i, input logic [15:0] a,
                           input logic [31:0] d, input logic rw);
        cmd_t e;
        e.cyc = c; e.req = i; e.addr = a; e.data = d; e.rw = rw;
        cmd_q.push_back(e);
    endtask

    task automatic exp_rd(input int c, input int i, input logic [31:0] d, input logic err);
        rd_t e;
        e.cyc = c; e.req = i; e.data = d; e.err = err;
        rd_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        up_cmd_vld = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_pio_outs", 64'({pio_bus.cmd_vld, pio_bus.rw, pio_bus.addr, pio_bus.data_w}), 64'd0);
            chk("rst_up_outs", 64'({up_cmd_ack, up_rd_vld, up_rd_err, up_data_r}), 64'd0);
        end else if (!done) begin
            if (pio_bus.cmd_vld) begin
                if (cmd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexp_cmd: got cmd addr %0h at cycle %0d expected none", pio_bus.addr, cyc);
                end else begin
                    ce = cmd_q.pop_front();
                    chk("cmd_cycle", 64'(cyc), 64'(ce.cyc));
                    chk("cmd_addr", 64'(pio_bus.addr), 64'(ce.addr));
                    chk("cmd_data_w", 64'(pio_bus.data_w), 64'(ce.data));
                    chk("cmd_rw", 64'(pio_bus.rw), 64'(ce.rw));
                    chk("cmd_ack", 64'(up_cmd_ack), 64'(1) << ce.req);
                end
            end else if (up_cmd_ack != '0) begin
                checks++; failures++;
                $display("FAIL stray_ack: got %0h at cycle %0d expected 0", up_cmd_ack, cyc);
            end
            if (up_rd_vld != '0) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexp_rd: got up_rd_vld %0h at cycle %0d expected none", up_rd_vld, cyc);
                end else begin
                    re = rd_q.pop_front();
                    chk("rd_cycle", 64'(cyc), 64'(re.cyc));
                    chk("rd_vld", 64'(up_rd_vld), 64'(1) << re.req);
                    chk("rd_data", 64'(up_data_r), 64'(re.data));
                    chk("rd_err", 64'(up_rd_err), 64'(re.err));
                end
            end
        end else if (!fin) begin
            fin <= 1'b1;
            chk("drain", 64'(cmd_q.size() + rd_q.size()), 64'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int t;
        up_cmd_vld = '0;
        up_addr    = '0;
        up_data_w  = '0;
        up_rw      = '0;
        pio_bus.rd_vld = 1'b0;
        pio_bus.data_r = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        #1;
        do_reset(3);
        tick();

        // single write from requester 2
        t = cyc;
        req(2, 16'h0010, 32'h1234_5678, 1'b1, 1);
        exp_cmd(t + 1, 2, 16'h0010, 32'h1234_5678, 1'b1);
        repeat (3) tick();

        // read round-trip, slave answers 3 cycles after cmd_vld
        t = cyc;
        req(1, 16'h0040, 32'h0, 1'b0, 1);
        exp_cmd(t + 1, 1, 16'h0040, 32'h0, 1'b0);
        repeat (4) tick();
        pio_bus.rd_vld = 1'b1;
        pio_bus.data_r = 32'hCAFE_F00D;
        exp_rd(t + 5, 1, 32'hCAFE_F00D, 1'b0);
        tick();
        pio_bus.rd_vld = 1'b0;
        repeat (2) tick();

        // fairness from reset: 0,1,2,3 then requester 0 again
        do_reset(2);
        tick();
        t = cyc;
        for (int i = 0; i < N; i++)
            req(i, 16'h0100 + 16'(i), 32'hA000_0000 + 32'(i), 1'b1, (i == 0) ? 2 : 1);
        exp_cmd(t + 1, 0, 16'h0100, 32'hA000_0000, 1'b1);
        exp_cmd(t + 3, 1, 16'h0101, 32'hA000_0001, 1'b1);
        exp_cmd(t + 5, 2, 16'h0102, 32'hA000_0002, 1'b1);
        exp_cmd(t + 7, 3, 16'h0103, 32'hA000_0003, 1'b1);
        exp_cmd(t + 9, 0, 16'h0100, 32'hA000_0000, 1'b1);
        repeat (11) tick();

        // back-pressure: requester 3 waits behind an outstanding read
        t = cyc;
        req(0, 16'h0200, 32'h0, 1'b0, 1);
        exp_cmd(t + 1, 0, 16'h0200, 32'h0, 1'b0);
        repeat (2) tick();
        req(3, 16'h0300, 32'h3333_3333, 1'b1, 1);
        exp_rd(t + 7, 0, 32'h1111_2222, 1'b0);
        exp_cmd(t + 8, 3, 16'h0300, 32'h3333_3333, 1'b1);
        repeat (4) tick();
        pio_bus.rd_vld = 1'b1;
        pio_bus.data_r = 32'h1111_2222;
        tick();
        pio_bus.rd_vld = 1'b0;
        repeat (3) tick();

`ifdef PIO_ARB_TIMEOUT_EN
        // slave never answers: timeout return 17 cycles after ISSUE
        t = cyc;
        req(1, 16'h0500, 32'h0, 1'b0, 1);
        exp_cmd(t + 1, 1, 16'h0500, 32'h0, 1'b0);
        repeat (3) tick();
        req(2, 16'h0600, 32'h6666_6666, 1'b1, 1);
        exp_rd(t + 18, 1, PIO_TIMEOUT_DATA, 1'b1);
        exp_cmd(t + 19, 2, 16'h0600, 32'h6666_6666, 1'b1);
        repeat (18) tick();
`endif

        // reset while waiting on a read; stray rd_vld afterwards is dropped
        t = cyc;
        req(1, 16'h0700, 32'h0, 1'b0, 1);
        exp_cmd(t + 1, 1, 16'h0700, 32'h0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        up_cmd_vld = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        pio_bus.rd_vld = 1'b1;
        pio_bus.data_r = 32'hBAD0_BAD0;
        tick();
        pio_bus.rd_vld = 1'b0;
        repeat (3) tick();
        t = cyc;
        req(0, 16'h0800, 32'h8080_8080, 1'b1, 1);
        req(2, 16'h0802, 32'h8282_8282, 1'b1, 1);
        exp_cmd(t + 1, 0, 16'h0800, 32'h8080_8080, 1'b1);
        exp_cmd(t + 3, 2, 16'h0802, 32'h8282_8282, 1'b1);
        repeat (5) tick();

        for (int k = 0; k < 100 && (cmd_q.size() + rd_q.size()) != 0; k++) tick();
        done = 1'b1;
        repeat (5) tick();
        $display("FAIL monitor_end: summary not reached");
        $fatal(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
